// File: rtl/counter_down_borrow.sv
// Loadable modulo-MOD down counter with a registered borrow pulse on wrap and an
// optional one-shot mode that parks at zero and raises done.
module counter_down_borrow #(
  parameter int MOD   = 7,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             oneshot,
  output logic             out_clk,
  output logic [WIDTH-1:0] cnt,
  output logic             done
);

  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MOD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Kept as a named module-level signal so checkers can bind to it directly.
  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] cnt_next;
  logic             mode;
  logic             mode_next;
  logic             borrow_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      mode    <= 1'b0;
      out_clk <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      mode    <= mode_next;
      out_clk <= borrow_next;
    end
  end

  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    mode_next   = mode;
    borrow_next = 1'b0;
    if (load) begin
      // Load wins over in; out-of-range presets saturate to the top count.
      cnt_next   = (load_val > CNT_MAX) ? CNT_MAX : load_val;
      mode_next  = oneshot;
      state_next = RUN;
    end else begin
      case (state)
        RUN: begin
          if (in) begin
            if (cnt != '0) begin
              cnt_next = cnt - 1'b1;
            end else begin
              borrow_next = 1'b1;
              if (mode) begin
                state_next = DONE;
              end else begin
                cnt_next = CNT_MAX;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign done = (state == DONE);

endmodule
